// File: rtl/counter_param.sv
// counter_param: WIDTH-bit synchronous up / down / down-by-STEP / load counter
// with a registered wrap flag (rco) and a combinational lookahead carry-out
// (cout) for cascading. Chaining stage k cin to stage k-1 cout gives a wider
// counter.
// Optional feature macro: COUNTER_PARAM_SAT_EN. When it is defined, modes
// 00/01/10 saturate instead of wrapping, rco flags clamped advances and cout
// is tied low. When it is undefined, the counter wraps.

module counter_param #(
  parameter int WIDTH = 4,
  parameter int STEP  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic             cin,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             cout
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_STEP = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam longint unsigned Q_MAX = (64'd1 << WIDTH) - 64'd1;
  localparam logic [WIDTH-1:0] ONES   = '1;
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  // Reject illegal configurations at elaboration time.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("counter_param: WIDTH=%0d outside 2..32", WIDTH);
  end
  if (STEP < 1 || longint'(STEP) > longint'(Q_MAX)) begin : g_bad_step
    $error("counter_param: STEP=%0d outside 1..2^WIDTH-1", STEP);
  end

  mode_e            mode;
  logic             adv;
  logic             terminal;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_adv;

  assign mode = mode_e'(modo);
  assign adv  = enb & cin;

  // Next value for an advance in the current mode, plus the terminal-count
  // condition (the advance that would wrap or borrow).
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    terminal = 1'b0;
    q_step   = Q;
    case (mode)
      MODE_UP: begin
        terminal = (Q == ONES);
        q_step   = Q + ONE;
      end
      MODE_DOWN: begin
        terminal = (Q == '0);
        q_step   = Q - ONE;
      end
      MODE_STEP: begin
        terminal = (Q < STEP_W);
        q_step   = Q - STEP_W;
      end
      default: begin
        terminal = 1'b0;
        q_step   = D;
      end
    endcase
  end

`ifdef COUNTER_PARAM_SAT_EN
  // Clamp instead of wrapping: up sticks at all-ones, both downs stick at 0.
  always_comb begin
    q_adv = q_step;
    if (terminal) q_adv = (mode == MODE_UP) ? ONES : '0;
  end

  // A saturating stage never ripples into a following stage.
  assign cout = 1'b0;
`else
  assign q_adv = q_step;

  // Lookahead carry: high in the cycle before the wrap so the next stage
  // advances on the same edge. terminal is already 0 in load mode.
  assign cout = adv & terminal;
`endif

  // Counter and wrap-flag registers; load needs enb only, counting needs enb
  // and cin together.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (reset) begin
      Q   <= '0;
      rco <= 1'b0;
    end else if (enb && mode == MODE_LOAD) begin
      Q   <= D;
      rco <= 1'b0;
    end else if (adv) begin
      Q   <= q_adv;
      rco <= terminal;
    end else begin
      rco <= 1'b0;
    end
  end

endmodule
